// File: rtl/taylor_pkg.sv
// Shared definitions for the taylor core multiply/divide unit:
// operand width, op encodings and FSM states.
package taylor_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the execute stage and the HI/LO multiply/divide unit.
interface muldiv_unit_if;
  import taylor_pkg::*;

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  ready, busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output ready, busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative 33-cycle multiply/divide with architectural HI/LO registers.
// Multiply and divide share one 64-bit working register and the iteration counter.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);
  import taylor_pkg::*;

  md_state_e          r_state;
  md_state_e          w_state_nx;
  logic [4:0]         r_cnt;
  logic               r_done;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_a_raw;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_dz;

  logic               w_long_op;
  logic               w_accept;
  logic               w_is_div;
  logic               w_signed;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_sh;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ge;
  logic [2*WIDTH-1:0] w_acc_nx;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  assign w_long_op = (bus.op[2] == 1'b0);
  assign w_accept  = bus.start && (r_state == IDLE) && w_long_op;
  assign w_is_div  = bus.op[1];
  assign w_signed  = !bus.op[0];
  assign w_a_mag   = magnitude(bus.a, w_signed);
  assign w_b_mag   = magnitude(bus.b, w_signed);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nx = RUN;
      RUN:     if (r_cnt == 5'd31) w_state_nx = FIX;
      FIX:     w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 5'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_done  <= (r_state == FIX);
      if (w_accept)
        r_cnt <= 5'd0;
      else if (r_state == RUN)
        r_cnt <= r_cnt + 5'd1;
    end
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_div_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_div_diff = w_div_sh - {1'b0, r_opnd};
    w_div_ge   = (w_div_sh >= {1'b0, r_opnd});
    if (r_is_div)
      w_acc_nx = {(w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0]),
                  r_acc[WIDTH-2:0], w_div_ge};
    else
      w_acc_nx = {w_mul_sum, r_acc[WIDTH-1:1]};
    w_prod = r_neg_res ? -r_acc : r_acc;
    w_quot = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  end

  // Working datapath needs no reset: it is always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_acc     <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
      r_opnd    <= w_is_div ? w_b_mag : w_a_mag;
      r_a_raw   <= bus.a;
      r_is_div  <= w_is_div;
      r_neg_res <= w_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      r_neg_rem <= w_signed && w_is_div && bus.a[WIDTH-1];
      r_dz      <= w_is_div && (bus.b == '0);
    end else if (r_state == RUN) begin
      r_acc <= w_acc_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_zero <= 1'b0;
    end else if (r_state == FIX) begin
      if (r_is_div && r_dz) begin
        r_hi       <= r_a_raw;
        r_lo       <= '1;
        r_div_zero <= 1'b1;
      end else if (r_is_div) begin
        r_hi <= w_rem;
        r_lo <= w_quot;
      end else begin
        r_hi <= w_prod[2*WIDTH-1:WIDTH];
        r_lo <= w_prod[WIDTH-1:0];
      end
    end else if (r_state == IDLE && bus.start) begin
      if (w_long_op)
        r_div_zero <= 1'b0;
      else if (bus.op == MD_MTHI)
        r_hi <= bus.a;
      else if (bus.op == MD_MTLO)
        r_lo <= bus.a;
    end
  end

  assign bus.busy     = (r_state != IDLE);
  assign bus.ready    = (r_state == IDLE);
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed test bench for muldiv_unit with hand-computed HI/LO results.
module tb_muldiv_unit;
  import taylor_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  muldiv_unit_if bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles, output int busy_cycles);
    present(op, a, b);
    cycles      = 0;
    busy_cycles = 0;
    while (!bus.done && cycles < 100) begin
      if (bus.busy) busy_cycles++;
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.div_zero !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b ready=%b dz=%b, expected 0 0 1 0",
               bus.busy, bus.done, bus.ready, bus.div_zero);
    end
    n_checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_hilo: hi=%h lo=%h, expected 0 0", bus.hi, bus.lo);
    end
  endtask

  task automatic test_multu_max;
    int cyc, bcyc;
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bcyc);
    n_checks++;
    if (cyc !== 33) begin
      n_errors++;
      $display("FAIL multu_latency: got %0d cycles, expected 33", cyc);
    end
    n_checks++;
    if (bcyc !== 33) begin
      n_errors++;
      $display("FAIL multu_busy_len: busy %0d cycles, expected 33", bcyc);
    end
    n_checks++;
    if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL multu_result: hi=%h lo=%h busy=%b, expected fffffffe 00000001 0",
               bus.hi, bus.lo, bus.busy);
    end
  endtask

  task automatic test_signed;
    int cyc, bcyc;
    run_op(MD_MULT, 32'hFFFF_FFFD, 32'd5, cyc, bcyc);
    n_checks++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFF1) begin
      n_errors++;
      $display("FAIL mult_signed: hi=%h lo=%h, expected ffffffff fffffff1", bus.hi, bus.lo);
    end
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, cyc, bcyc);
    n_checks++;
    if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
      n_errors++;
      $display("FAIL div_signed: lo=%h hi=%h, expected fffffffd ffffffff", bus.lo, bus.hi);
    end
    run_op(MD_DIV, 32'd100, 32'hFFFF_FFF9, cyc, bcyc);
    n_checks++;
    if (bus.lo !== 32'hFFFF_FFF2 || bus.hi !== 32'd2) begin
      n_errors++;
      $display("FAIL div_neg_divisor: lo=%h hi=%h, expected fffffff2 00000002", bus.lo, bus.hi);
    end
  endtask

  task automatic test_div_zero;
    int cyc, bcyc;
    run_op(MD_DIVU, 32'd100, 32'd0, cyc, bcyc);
    n_checks++;
    if (cyc !== 33 || bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'h0000_0064 || bus.div_zero !== 1'b1) begin
      n_errors++;
      $display("FAIL divu_zero: cyc=%0d lo=%h hi=%h dz=%b, expected 33 ffffffff 00000064 1",
               cyc, bus.lo, bus.hi, bus.div_zero);
    end
    run_op(MD_DIV, 32'hFFFF_FF9C, 32'd0, cyc, bcyc);
    n_checks++;
    if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'hFFFF_FF9C || bus.div_zero !== 1'b1) begin
      n_errors++;
      $display("FAIL div_zero_signed: lo=%h hi=%h dz=%b, expected ffffffff ffffff9c 1",
               bus.lo, bus.hi, bus.div_zero);
    end
    run_op(MD_MULTU, 32'd2, 32'd3, cyc, bcyc);
    n_checks++;
    if (bus.div_zero !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'd6) begin
      n_errors++;
      $display("FAIL dz_clear: dz=%b hi=%h lo=%h, expected 0 00000000 00000006",
               bus.div_zero, bus.hi, bus.lo);
    end
  endtask

  task automatic test_overflow;
    int cyc, bcyc;
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bcyc);
    n_checks++;
    if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0 || bus.div_zero !== 1'b0) begin
      n_errors++;
      $display("FAIL div_ovf: lo=%h hi=%h dz=%b, expected 80000000 00000000 0",
               bus.lo, bus.hi, bus.div_zero);
    end
    run_op(MD_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bcyc);
    n_checks++;
    if (bus.lo !== 32'h0 || bus.hi !== 32'h8000_0000) begin
      n_errors++;
      $display("FAIL divu_big: lo=%h hi=%h, expected 00000000 80000000", bus.lo, bus.hi);
    end
  endtask

  task automatic test_move_and_ignore;
    int cyc;
    present(MD_MTHI, 32'h1234_5678, 32'h0);
    n_checks++;
    if (bus.hi !== 32'h1234_5678 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL mthi: hi=%h done=%b busy=%b, expected 12345678 0 0", bus.hi, bus.done, bus.busy);
    end
    present(MD_MTLO, 32'hCAFE_F00D, 32'h0);
    n_checks++;
    if (bus.lo !== 32'hCAFE_F00D || bus.hi !== 32'h1234_5678 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL mtlo: lo=%h hi=%h busy=%b, expected cafef00d 12345678 0", bus.lo, bus.hi, bus.busy);
    end
    present(3'b110, 32'h1111_1111, 32'h2222_2222);
    n_checks++;
    if (bus.lo !== 32'hCAFE_F00D || bus.hi !== 32'h1234_5678 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_errors++;
      $display("FAIL undef_op: lo=%h hi=%h busy=%b done=%b, expected cafef00d 12345678 0 0",
               bus.lo, bus.hi, bus.busy, bus.done);
    end
    present(MD_MULTU, 32'd7, 32'd6);
    repeat (5) @(posedge clk);
    present(MD_MTLO, 32'hDEAD_BEEF, 32'h0);
    present(MD_DIVU, 32'd50, 32'd0);
    n_checks++;
    if (bus.lo !== 32'hCAFE_F00D || bus.hi !== 32'h1234_5678 || bus.busy !== 1'b1) begin
      n_errors++;
      $display("FAIL busy_ignore: lo=%h hi=%h busy=%b, expected cafef00d 12345678 1",
               bus.lo, bus.hi, bus.busy);
    end
    cyc = 0;
    while (!bus.done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.lo !== 32'd42 || bus.hi !== 32'h0 || bus.div_zero !== 1'b0) begin
      n_errors++;
      $display("FAIL inflight_lands: done=%b lo=%h hi=%h dz=%b, expected 1 0000002a 00000000 0",
               bus.done, bus.lo, bus.hi, bus.div_zero);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL done_pulse: done=%b busy=%b, expected 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_reset_abort;
    int cyc, bcyc;
    present(MD_MTHI, 32'h0000_0055, 32'h0);
    present(MD_MULTU, 32'd7, 32'd9);
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_abort: busy=%b hi=%h lo=%h ready=%b, expected 0 0 0 1",
               bus.busy, bus.hi, bus.lo, bus.ready);
    end
    @(negedge clk);
    rst = 1'b1;
    run_op(MD_DIVU, 32'd9, 32'd2, cyc, bcyc);
    n_checks++;
    if (cyc !== 33 || bus.lo !== 32'd4 || bus.hi !== 32'd1) begin
      n_errors++;
      $display("FAIL after_reset_divu: cyc=%0d lo=%h hi=%h, expected 33 00000004 00000001",
               cyc, bus.lo, bus.hi);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, bcyc;
    run_op(MD_MULTU, 32'h0001_0000, 32'h0001_0000, cyc, bcyc);
    n_checks++;
    if (cyc !== 33 || bus.hi !== 32'd1 || bus.lo !== 32'd0) begin
      n_errors++;
      $display("FAIL b2b_first: cyc=%0d hi=%h lo=%h, expected 33 00000001 00000000", cyc, bus.hi, bus.lo);
    end
    run_op(MD_MULT, 32'h8000_0000, 32'h8000_0000, cyc, bcyc);
    n_checks++;
    if (cyc !== 33 || bus.hi !== 32'h4000_0000 || bus.lo !== 32'h0) begin
      n_errors++;
      $display("FAIL b2b_second: cyc=%0d hi=%h lo=%h, expected 33 40000000 00000000", cyc, bus.hi, bus.lo);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk);
    rst = 1'b1;
    test_multu_max;
    test_signed;
    test_div_zero;
    test_overflow;
    test_move_and_ignore;
    test_reset_abort;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
